// File: rtl/l1_seq_if.sv
// rtl/l1_seq_if.sv - handshake and memory-port bundle for the l1_seq layer-1 sequencer
//
// Signals
//   start, abort        : run request / cancel, driven by the controller
//   busy, done          : run status back to the controller
//   if_addr_a/b, if_q_a/b : input-feature RAM dual read port (data one cycle after address)
//   w_addr_a/b, w_q_a/b   : weight ROM dual read port (data one cycle after address)
//   l1_addr, l1_data, l1_we : result RAM write port
//
// Modports
//   slave  : the sequencer itself
//   master : the surrounding system (controller plus the memories that answer reads)
interface l1_seq_if;
   logic        start;
   logic        abort;
   logic        busy;
   logic        done;
   logic [9:0]  if_addr_a;
   logic [9:0]  if_addr_b;
   logic [7:0]  if_q_a;
   logic [7:0]  if_q_b;
   logic [13:0] w_addr_a;
   logic [13:0] w_addr_b;
   logic [7:0]  w_q_a;
   logic [7:0]  w_q_b;
   logic [4:0]  l1_addr;
   logic [7:0]  l1_data;
   logic        l1_we;

   modport slave (
      input  start, abort, if_q_a, if_q_b, w_q_a, w_q_b,
      output busy, done, if_addr_a, if_addr_b, w_addr_a, w_addr_b,
             l1_addr, l1_data, l1_we
   );

   modport master (
      output start, abort, if_q_a, if_q_b, w_q_a, w_q_b,
      input  busy, done, if_addr_a, if_addr_b, w_addr_a, w_addr_b,
             l1_addr, l1_data, l1_we
   );
endinterface

// File: rtl/l1_seq.sv
// rtl/l1_seq.sv - layer-1 dense neuron sequencer: dual-issue MAC with ReLU-saturated byte output
//
// For each of N_HID neurons, reads N_IN feature/weight pairs two per cycle,
// accumulates feature*weight into a 26-bit signed register, then writes
// clamp(acc >>> SHIFT, 0, 255) to the L1 result RAM at the neuron index.
//
// Ports
//   ck  : clock, all state changes on the rising edge
//   rb  : asynchronous active-low reset
//   bus : l1_seq_if.slave - start/abort/busy/done, feature and weight
//         read ports, L1 result write port
module l1_seq #(
   parameter int N_IN  = 784,
   parameter int N_HID = 20,
   parameter int SHIFT = 8
) (
   input  logic    ck,
   input  logic    rb,
   l1_seq_if.slave bus
);

   localparam logic [8:0]  K_LAST = 9'(N_IN / 2 - 1);
   localparam logic [4:0]  N_LAST = 5'(N_HID - 1);
   localparam logic [13:0] N_STEP = 14'(N_IN);

   typedef enum logic [2:0] {IDLE, RUN, DRAIN, WRITE, FIN} state_t;

   state_t             state;
   state_t             state_nx;
   logic [8:0]         k;
   logic [4:0]         n;
   logic [13:0]        base;      // n*N_IN, kept incrementally to avoid a multiplier
   logic signed [25:0] acc;
   logic               vld;       // read data on the memory ports belongs to the previous issue

   logic signed [16:0] feat_a, feat_b;
   logic signed [16:0] wt_a, wt_b;
   logic signed [16:0] prod_a, prod_b;
   logic signed [25:0] acc_sum;
   logic signed [25:0] acc_sh;
   logic [7:0]         relu_q;
   logic [9:0]         pair_a, pair_b;

   // Features are unsigned bytes: zero-extend. Weights are signed: sign-extend.
   // 255 * -128 still fits the 17-bit product.
   assign feat_a = {9'd0, bus.if_q_a};
   assign feat_b = {9'd0, bus.if_q_b};
   assign wt_a   = {{9{bus.w_q_a[7]}}, bus.w_q_a};
   assign wt_b   = {{9{bus.w_q_b[7]}}, bus.w_q_b};
   assign prod_a = feat_a * wt_a;
   assign prod_b = feat_b * wt_b;
   assign acc_sum = acc + {{9{prod_a[16]}}, prod_a} + {{9{prod_b[16]}}, prod_b};

   assign pair_a = {k, 1'b0};
   assign pair_b = {k, 1'b1};

   // Non-positive sums map to 0; positive sums are scaled then clamped to a byte.
   assign acc_sh = acc >>> SHIFT;

   always_comb begin
      relu_q = 8'd0;
      if (acc > 26'sd0) begin
         if (acc_sh > 26'sd255) begin
            relu_q = 8'hFF;
         end else begin
            relu_q = acc_sh[7:0];
         end
      end
   end

   always_ff @(posedge ck or negedge rb) begin
      if (!rb) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next state and all outputs. Outputs depend only on state/registers
   // (plus abort on l1_we), so reset drives every output to 0 immediately.
   always_comb begin
      state_nx      = state;
      bus.busy      = 1'b0;
      bus.done      = 1'b0;
      bus.l1_we     = 1'b0;
      bus.l1_addr   = 5'd0;
      bus.l1_data   = 8'd0;
      bus.if_addr_a = 10'd0;
      bus.if_addr_b = 10'd0;
      bus.w_addr_a  = 14'd0;
      bus.w_addr_b  = 14'd0;
      case (state)
         IDLE: begin
            // abort is deliberately ignored here, so start wins
            if (bus.start) begin
               state_nx = RUN;
            end
         end
         RUN: begin
            bus.busy      = 1'b1;
            bus.if_addr_a = pair_a;
            bus.if_addr_b = pair_b;
            bus.w_addr_a  = base + {4'd0, pair_a};
            bus.w_addr_b  = base + {4'd0, pair_b};
            if (bus.abort) begin
               state_nx = IDLE;
            end else if (k == K_LAST) begin
               state_nx = DRAIN;
            end
         end
         DRAIN: begin
            bus.busy = 1'b1;
            state_nx = bus.abort ? IDLE : WRITE;
         end
         WRITE: begin
            bus.busy    = 1'b1;
            bus.l1_we   = !bus.abort;
            bus.l1_addr = n;
            bus.l1_data = relu_q;
            if (bus.abort) begin
               state_nx = IDLE;
            end else if (n == N_LAST) begin
               state_nx = FIN;
            end else begin
               state_nx = RUN;
            end
         end
         FIN: begin
            bus.done = 1'b1;
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   always_ff @(posedge ck or negedge rb) begin
      if (!rb) begin
         k    <= 9'd0;
         n    <= 5'd0;
         base <= 14'd0;
         acc  <= 26'sd0;
         vld  <= 1'b0;
      end else begin
         vld <= (state == RUN) && !bus.abort;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  k    <= 9'd0;
                  n    <= 5'd0;
                  base <= 14'd0;
                  acc  <= 26'sd0;
               end
            end
            RUN: begin
               // k wraps harmlessly past K_LAST; WRITE clears it before reuse
               k <= k + 9'd1;
               if (vld) begin
                  acc <= acc_sum;
               end
            end
            DRAIN: begin
               if (vld) begin
                  acc <= acc_sum;
               end
            end
            WRITE: begin
               acc <= 26'sd0;
               k   <= 9'd0;
               if (n != N_LAST) begin
                  n    <= n + 5'd1;
                  base <= base + N_STEP;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_l1_seq.sv
// tb/tb_l1_seq.sv - self-checking bench for l1_seq: vector table, abort/reset sequences, randomized runs
module tb_l1_seq;
   localparam int NA = 4;
   localparam int HA = 2;
   localparam int SA = 0;
   localparam int NB = 8;
   localparam int HB = 3;
   localparam int SB = 8;
   localparam int NC = 784;
   localparam int HC = 20;
   localparam int SC = 8;
   localparam int BUDGET = 10000;

   logic ck = 1'b0;
   logic rb;
   always #5 ck = ~ck;

   l1_seq_if ifa ();
   l1_seq_if ifb ();
   l1_seq_if ifc ();

   l1_seq #(.N_IN(NA), .N_HID(HA), .SHIFT(SA)) u_a (.ck(ck), .rb(rb), .bus(ifa));
   l1_seq #(.N_IN(NB), .N_HID(HB), .SHIFT(SB)) u_b (.ck(ck), .rb(rb), .bus(ifb));
   l1_seq u_c (.ck(ck), .rb(rb), .bus(ifc));

   logic [7:0] fm [3][1024];
   logic [7:0] wm [3][16384];

   always @(posedge ck) begin
      ifa.if_q_a <= fm[0][ifa.if_addr_a];
      ifa.if_q_b <= fm[0][ifa.if_addr_b];
      ifa.w_q_a  <= wm[0][ifa.w_addr_a];
      ifa.w_q_b  <= wm[0][ifa.w_addr_b];
      ifb.if_q_a <= fm[1][ifb.if_addr_a];
      ifb.if_q_b <= fm[1][ifb.if_addr_b];
      ifb.w_q_a  <= wm[1][ifb.w_addr_a];
      ifb.w_q_b  <= wm[1][ifb.w_addr_b];
      ifc.if_q_a <= fm[2][ifc.if_addr_a];
      ifc.if_q_b <= fm[2][ifc.if_addr_b];
      ifc.w_q_a  <= wm[2][ifc.w_addr_a];
      ifc.w_q_b  <= wm[2][ifc.w_addr_b];
   end

   logic [12:0] wr_a [$];
   logic [12:0] wr_b [$];
   logic [12:0] wr_c [$];
   int          done_n [3];
   logic [13:0] tr_wa [$];
   logic [9:0]  tr_ifb [$];
   logic        tr_we [$];

   always @(negedge ck) begin
      if (ifa.l1_we) wr_a.push_back({ifa.l1_addr, ifa.l1_data});
      if (ifb.l1_we) wr_b.push_back({ifb.l1_addr, ifb.l1_data});
      if (ifc.l1_we) wr_c.push_back({ifc.l1_addr, ifc.l1_data});
      if (ifa.done) done_n[0]++;
      if (ifb.done) done_n[1]++;
      if (ifc.done) done_n[2]++;
      if (ifa.busy) begin
         tr_wa.push_back(ifa.w_addr_a);
         tr_ifb.push_back(ifa.if_addr_b);
         tr_we.push_back(ifa.l1_we);
      end
   end

   int total = 0;
   int bad = 0;
   int mark_wr [3];
   int mark_done [3];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   function automatic int n_in(input int w);
      return (w == 0) ? NA : (w == 1) ? NB : NC;
   endfunction

   function automatic int h_of(input int w);
      return (w == 0) ? HA : (w == 1) ? HB : HC;
   endfunction

   function automatic int sh_of(input int w);
      return (w == 0) ? SA : (w == 1) ? SB : SC;
   endfunction

   function automatic int wr_cnt(input int w);
      case (w)
         0:       return wr_a.size();
         1:       return wr_b.size();
         default: return wr_c.size();
      endcase
   endfunction

   function automatic logic [12:0] wr_at(input int w, input int i);
      case (w)
         0:       return wr_a[i];
         1:       return wr_b[i];
         default: return wr_c[i];
      endcase
   endfunction

   function automatic logic is_done(input int w);
      case (w)
         0:       return ifa.done;
         1:       return ifb.done;
         default: return ifc.done;
      endcase
   endfunction

   function automatic logic [63:0] outs(input int w);
      case (w)
         0: return {ifa.busy, ifa.done, ifa.l1_we, ifa.l1_addr, ifa.l1_data,
                    ifa.if_addr_a, ifa.if_addr_b, ifa.w_addr_a, ifa.w_addr_b};
         1: return {ifb.busy, ifb.done, ifb.l1_we, ifb.l1_addr, ifb.l1_data,
                    ifb.if_addr_a, ifb.if_addr_b, ifb.w_addr_a, ifb.w_addr_b};
         default: return {ifc.busy, ifc.done, ifc.l1_we, ifc.l1_addr, ifc.l1_data,
                          ifc.if_addr_a, ifc.if_addr_b, ifc.w_addr_a, ifc.w_addr_b};
      endcase
   endfunction

   task automatic set_start(input int w, input logic v);
      case (w)
         0:       ifa.start = v;
         1:       ifb.start = v;
         default: ifc.start = v;
      endcase
   endtask

   task automatic mark(input int w);
      mark_wr[w]   = wr_cnt(w);
      mark_done[w] = done_n[w];
   endtask

   // Reference: dot product of unsigned features and signed weights,
   // negatives clipped to 0, scaled by 2^SHIFT, clamped to 255.
   function automatic logic [7:0] model(input int w, input int n);
      longint acc = 0;
      longint q;
      for (int i = 0; i < n_in(w); i++)
         acc += longint'(fm[w][i]) * longint'(byte'(wm[w][n * n_in(w) + i]));
      if (acc <= 0) return 8'd0;
      q = acc / (longint'(1) << sh_of(w));
      return (q > 255) ? 8'd255 : q[7:0];
   endfunction

   task automatic model_exp(input int w, output logic [7:0] exp [32]);
      for (int i = 0; i < 32; i++) exp[i] = (i < h_of(w)) ? model(w, i) : 8'd0;
   endtask

   task automatic fill_rand(input int w);
      for (int i = 0; i < n_in(w); i++) fm[w][i] = 8'($urandom);
      for (int i = 0; i < n_in(w) * h_of(w); i++) wm[w][i] = 8'($urandom);
   endtask

   // Raises START just after an edge; edges counts clock edges from there until DONE is seen.
   task automatic run(input int w, input bit spam, input string tag, output int edges);
      @(posedge ck);
      #1;
      set_start(w, 1'b1);
      edges = 0;
      do begin
         @(posedge ck);
         #1;
         edges++;
         set_start(w, spam ? 1'($urandom_range(0, 1)) : 1'b0);
      end while (!is_done(w) && edges < BUDGET);
      set_start(w, 1'b0);
      chk({tag, ".done_seen"}, is_done(w), 1);
   endtask

   task automatic check_run(input int w, input string tag, input logic [7:0] exp [32]);
      int cnt;
      logic [12:0] e;
      repeat (3) @(posedge ck);
      #1;
      cnt = wr_cnt(w) - mark_wr[w];
      chk({tag, ".we_count"}, cnt, h_of(w));
      for (int i = 0; i < cnt && i < h_of(w); i++) begin
         e = wr_at(w, mark_wr[w] + i);
         chk($sformatf("%s.addr%0d", tag, i), e[12:8], i);
         chk($sformatf("%s.data%0d", tag, i), e[7:0], exp[i]);
      end
      chk({tag, ".done_count"}, done_n[w] - mark_done[w], 1);
   endtask

   typedef struct packed {
      logic [31:0] f;     // feature i in bits [8i+7:8i]
      logic [7:0]  w0;    // every weight of neuron 0
      logic [7:0]  w1;    // every weight of neuron 1
      logic [7:0]  e0;
      logic [7:0]  e1;
   } vec_t;

   initial begin
      vec_t        tbl [6];
      logic [7:0]  exp [32];
      logic [13:0] ex_wa [8];
      logic [9:0]  ex_ifb [8];
      logic        ex_we [8];
      int          edges;
      int          tmark;
      int          wait_n;

      tbl[0] = '{32'h281E140A, 8'h01, 8'hFF, 8'd100, 8'd0};
      tbl[1] = '{32'hFFFFFFFF, 8'h7F, 8'h80, 8'd255, 8'd0};
      tbl[2] = '{32'hFF000000, 8'h01, 8'h02, 8'd255, 8'd255};
      tbl[3] = '{32'h00000001, 8'h00, 8'h01, 8'd0,   8'd1};
      tbl[4] = '{32'h00000064, 8'hFF, 8'h02, 8'd0,   8'd200};
      tbl[5] = '{32'h40404040, 8'h01, 8'hFF, 8'd255, 8'd0};
      ex_wa  = '{14'd0, 14'd2, 14'd0, 14'd0, 14'd4, 14'd6, 14'd0, 14'd0};
      ex_ifb = '{10'd1, 10'd3, 10'd0, 10'd0, 10'd1, 10'd3, 10'd0, 10'd0};
      ex_we  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

      ifa.start = 1'b0; ifa.abort = 1'b0;
      ifb.start = 1'b0; ifb.abort = 1'b0;
      ifc.start = 1'b0; ifc.abort = 1'b0;
      rb = 1'b0;
      repeat (3) @(posedge ck);
      #1;
      chk("reset_outs_a", outs(0), 0);
      chk("reset_outs_b", outs(1), 0);
      chk("reset_outs_c", outs(2), 0);
      rb = 1'b1;

      // Directed vectors on the 4-input, 2-neuron, SHIFT=0 instance
      for (int v = 0; v < 6; v++) begin
         for (int i = 0; i < NA; i++) begin
            fm[0][i]      = tbl[v].f[8*i +: 8];
            wm[0][i]      = tbl[v].w0;
            wm[0][NA + i] = tbl[v].w1;
         end
         mark(0);
         tmark = tr_wa.size();
         run(0, 1'b0, $sformatf("vec%0d", v), edges);
         chk($sformatf("vec%0d.latency", v), edges, 9);
         exp = '{default: 8'd0};
         exp[0] = tbl[v].e0;
         exp[1] = tbl[v].e1;
         check_run(0, $sformatf("vec%0d", v), exp);
         if (v == 0) begin
            chk("trace.busy_cycles", tr_wa.size() - tmark, 8);
            for (int i = 0; i < 8 && tmark + i < tr_wa.size(); i++) begin
               chk($sformatf("trace.w_addr_a%0d", i), tr_wa[tmark + i], ex_wa[i]);
               chk($sformatf("trace.if_addr_b%0d", i), tr_ifb[tmark + i], ex_ifb[i]);
               chk($sformatf("trace.l1_we%0d", i), tr_we[tmark + i], ex_we[i]);
            end
         end
      end

      // START and ABORT together in IDLE: the run starts and completes
      mark(0);
      @(posedge ck); #1;
      ifa.start = 1'b1; ifa.abort = 1'b1;
      @(posedge ck); #1;
      ifa.start = 1'b0; ifa.abort = 1'b0;
      chk("start_abort.busy", ifa.busy, 1);
      wait_n = 0;
      while (!ifa.done && wait_n < 100) begin
         @(posedge ck); #1;
         wait_n++;
      end
      model_exp(0, exp);
      check_run(0, "start_abort", exp);

      // ABORT during neuron 1 RUN
      mark(0);
      @(posedge ck); #1; ifa.start = 1'b1;
      @(posedge ck); #1; ifa.start = 1'b0;
      repeat (4) @(posedge ck);
      #1;
      chk("abort_run.n1_addr", ifa.w_addr_a, 4);
      ifa.abort = 1'b1;
      @(posedge ck); #1;
      ifa.abort = 1'b0;
      chk("abort_run.busy", ifa.busy, 0);
      repeat (10) @(posedge ck);
      #1;
      chk("abort_run.we_count", wr_cnt(0) - mark_wr[0], 1);
      if (wr_cnt(0) > mark_wr[0]) chk("abort_run.kept_data", wr_at(0, mark_wr[0]), {5'd0, model(0, 0)});
      chk("abort_run.done_count", done_n[0] - mark_done[0], 0);

      // ABORT in WRITE suppresses the write in that same cycle
      mark(0);
      @(posedge ck); #1; ifa.start = 1'b1;
      @(posedge ck); #1; ifa.start = 1'b0;
      repeat (3) @(posedge ck);
      #1;
      chk("abort_wr.we_before", ifa.l1_we, 1);
      ifa.abort = 1'b1;
      #1;
      chk("abort_wr.we_forced", ifa.l1_we, 0);
      @(posedge ck); #1;
      ifa.abort = 1'b0;
      chk("abort_wr.busy", ifa.busy, 0);
      repeat (6) @(posedge ck);
      #1;
      chk("abort_wr.we_count", wr_cnt(0) - mark_wr[0], 0);
      chk("abort_wr.done_count", done_n[0] - mark_done[0], 0);

      // Reset pulsed mid-run during neuron 1
      mark(0);
      @(posedge ck); #1; ifa.start = 1'b1;
      @(posedge ck); #1; ifa.start = 1'b0;
      repeat (5) @(posedge ck);
      #1;
      chk("rst_mid.active", ifa.w_addr_a, 6);
      rb = 1'b0;
      #1;
      chk("rst_mid.outs_async", outs(0), 0);
      repeat (2) @(posedge ck);
      #1;
      rb = 1'b1;
      repeat (8) @(posedge ck);
      #1;
      chk("rst_mid.busy_after", ifa.busy, 0);
      chk("rst_mid.we_count", wr_cnt(0) - mark_wr[0], 1);
      chk("rst_mid.done_count", done_n[0] - mark_done[0], 0);
      mark(0);
      model_exp(0, exp);
      run(0, 1'b0, "rst_resume", edges);
      check_run(0, "rst_resume", exp);

      // SHIFT=8: acc = 100*10 = 1000 -> 1000>>8 = 3
      for (int i = 0; i < NB; i++) fm[1][i] = 8'd0;
      for (int i = 0; i < NB * HB; i++) wm[1][i] = 8'd0;
      fm[1][0] = 8'd100;
      wm[1][0] = 8'd10;
      mark(1);
      run(1, 1'b0, "shift8", edges);
      exp = '{default: 8'd0};
      exp[0] = 8'd3;
      check_run(1, "shift8", exp);

      // Randomized runs against the reference model on both small instances
      for (int r = 0; r < 8; r++) begin
         int w;
         w = r % 2;
         fill_rand(w);
         model_exp(w, exp);
         mark(w);
         run(w, 1'b0, $sformatf("rand%0d", r), edges);
         chk($sformatf("rand%0d.latency", r), edges, h_of(w) * (n_in(w) / 2 + 2) + 1);
         check_run(w, $sformatf("rand%0d", r), exp);
      end

      // Default parameters, START toggled throughout the run
      fill_rand(2);
      model_exp(2, exp);
      mark(2);
      run(2, 1'b1, "full", edges);
      chk("full.latency", edges, 7881);
      check_run(2, "full", exp);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
